alu_sequencer: RTL and testbench

Instruction-issuing front end for the 8-bit combinational ALU. It accepts 16-bit instruction words over a valid/ready handshake, reads operands from a 4-entry register file, and drives the ALU's opcode, operand and carry-in ports. It captures the ALU result and carry-out, writes back to the register file, and maintains carry and zero flags. It sits between an upstream instruction source (host or test driver) and the ALU, and initiates every request the ALU serves.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_regfile.sv | 52 +++++
 rtl/alu_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer and the ALU bench: opcodes,
// instruction field layout, FSM state encoding and small decode helpers.
package alu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned REG_AW  = 2;

  // Instruction field bit positions
  localparam int unsigned OPC_LSB       = 12;
  localparam int unsigned DST_LSB       = 10;
  localparam int unsigned SRCA_LSB      = 8;
  localparam int unsigned SRCB_LSB      = 6;
  localparam int unsigned USE_CARRY_BIT = 5;
  localparam int unsigned IMM_W         = 8;

  // ALU opcodes, passed through unchanged to the ALU
  localparam logic [OPC_W-1:0] OP_ADD    = 4'h0;
  localparam logic [OPC_W-1:0] OP_SUB    = 4'h1;
  localparam logic [OPC_W-1:0] OP_LSHIFT = 4'h2;
  localparam logic [OPC_W-1:0] OP_RSHIFT = 4'h3;
  localparam logic [OPC_W-1:0] OP_XOR    = 4'h4;
  localparam logic [OPC_W-1:0] OP_CMP    = 4'h5;
  localparam logic [OPC_W-1:0] OP_AND    = 4'h6;
  localparam logic [OPC_W-1:0] OP_NAND   = 4'h7;
  localparam logic [OPC_W-1:0] OP_OR     = 4'h8;
  localparam logic [OPC_W-1:0] OP_NOR    = 4'h9;
  localparam logic [OPC_W-1:0] OP_LOADI  = 4'hF;

  // Instruction word layout; for LOADI the low byte is the immediate
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
    logic              use_carry;
    logic [4:0]        rsvd;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op <= OP_NOR);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NUM_REGS x DATA_W, one synchronous write port, two
// combinational operand read ports and a combinational debug read port.
// Ports: clk/rst (async active-high), we/waddr/wdata write port,
// raddr_a/rdata_a, raddr_b/rdata_b, raddr_dbg/rdata_dbg read ports.
module alu_regfile #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned AW       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     raddr_dbg,
  output logic [DATA_W-1:0] rdata_dbg
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Write-port update
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rdata_a   = regs_q[raddr_a];
  assign rdata_b   = regs_q[raddr_b];
  assign rdata_dbg = regs_q[raddr_dbg];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction-issuing front end for the 8-bit combinational ALU.
// Accepts one instruction per handshake, drives registered ALU ports for one
// EXEC cycle, then writes back, updates flags and pulses res_valid.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_instr instruction
// handshake; alu_opcode/alu_opA/alu_opB/alu_cin to the ALU; alu_result/alu_cout
// from the ALU; res_valid/res_data retire pulse; flag_c/flag_z flags;
// rd_addr/rd_data combinational debug read of the register file.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  output logic [OPC_W-1:0]     alu_opcode,
  output logic [DATA_W-1:0]    alu_opA,
  output logic [DATA_W-1:0]    alu_opB,
  output logic                 alu_cin,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_cout,
  output logic                 res_valid,
  output logic [DATA_W-1:0]    res_data,
  output logic                 flag_c,
  output logic                 flag_z,
  input  logic [REG_AW-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data
);

  seq_state_e        state_q, state_d;
  logic [OPC_W-1:0]  op_q, op_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [OPC_W-1:0]  alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_opa_q, alu_opa_d;
  logic [DATA_W-1:0] alu_opb_q, alu_opb_d;
  logic              alu_cin_q, alu_cin_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;
  logic              in_ready_q, in_ready_d;

  instr_t            in_fields;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;

  assign in_fields = instr_t'(in_instr);

  // Operands are read in IDLE, before any writeback of this instruction,
  // so a source equal to dst always sees the old value.
  alu_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .AW       (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (rf_we),
    .waddr     (dst_q),
    .wdata     (rf_wdata),
    .raddr_a   (in_fields.src_a),
    .rdata_a   (rf_rdata_a),
    .raddr_b   (in_fields.src_b),
    .rdata_b   (rf_rdata_b),
    .raddr_dbg (rd_addr),
    .rdata_dbg (rd_data)
  );

  // Next-state and datapath control
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dst_d        = dst_q;
    imm_d        = imm_q;
    alu_opcode_d = alu_opcode_q;
    alu_opa_d    = alu_opa_q;
    alu_opb_d    = alu_opb_q;
    alu_cin_d    = alu_cin_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    flag_c_d     = flag_c_q;
    flag_z_d     = flag_z_q;
    rf_we        = 1'b0;
    rf_wdata     = '0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_fields.opcode;
          dst_d   = in_fields.dst;
          imm_d   = in_instr[IMM_W-1:0];
          state_d = ST_EXEC;
          // ALU ports only move for real ALU ops; otherwise they hold.
          if (is_alu_op(in_fields.opcode)) begin
            alu_opcode_d = in_fields.opcode;
            alu_opa_d    = rf_rdata_a;
            alu_opb_d    = rf_rdata_b;
            alu_cin_d    = in_fields.use_carry & flag_c_q;
          end
        end
      end
      ST_EXEC: begin
        state_d     = ST_DONE;
        res_valid_d = 1'b1;
        if (is_alu_op(op_q)) begin
          rf_we      = 1'b1;
          rf_wdata   = alu_result;
          res_data_d = alu_result;
          flag_z_d   = (alu_result == '0);
          if (op_q == OP_ADD) begin
            flag_c_d = alu_cout;
          end
        end else if (op_q == OP_LOADI) begin
          rf_we      = 1'b1;
          rf_wdata   = DATA_W'(imm_q);
          res_data_d = DATA_W'(imm_q);
        end else begin
          res_data_d = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      dst_q        <= '0;
      imm_q        <= '0;
      alu_opcode_q <= '0;
      alu_opa_q    <= '0;
      alu_opb_q    <= '0;
      alu_cin_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dst_q        <= dst_d;
      imm_q        <= imm_d;
      alu_opcode_q <= alu_opcode_d;
      alu_opa_q    <= alu_opa_d;
      alu_opb_q    <= alu_opb_d;
      alu_cin_q    <= alu_cin_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      flag_c_q     <= flag_c_d;
      flag_z_q     <= flag_z_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_opA    = alu_opa_q;
  assign alu_opB    = alu_opb_q;
  assign alu_cin    = alu_cin_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign flag_c     = flag_c_q;
  assign flag_z     = flag_z_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioral 8-bit ALU closes the loop, a table
// of directed instructions with hand-computed results is issued in order,
// followed by hand-written back-to-back and reset-in-EXEC sequences.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_opA;
  logic [7:0]  alu_opB;
  logic        alu_cin;
  logic [7:0]  alu_result;
  logic        alu_cout;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        flag_c;
  logic        flag_z;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;

  int n_cmp;
  int n_err;

  alu_sequencer #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_opcode (alu_opcode),
    .alu_opA    (alu_opA),
    .alu_opB    (alu_opB),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioral ALU standing in for the real combinational ALU
  always_comb begin
    logic [8:0] t;
    t          = '0;
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_opcode)
      OP_ADD:    begin t = {1'b0, alu_opA} + {1'b0, alu_opB} + {8'h00, alu_cin};
                       alu_result = t[7:0]; alu_cout = t[8]; end
      OP_SUB:    begin t = {1'b0, alu_opA} - {1'b0, alu_opB} - {8'h00, alu_cin};
                       alu_result = t[7:0]; alu_cout = t[8]; end
      OP_LSHIFT: begin alu_result = {alu_opA[6:0], alu_cin}; alu_cout = alu_opA[7]; end
      OP_RSHIFT: begin alu_result = {alu_cin, alu_opA[7:1]}; alu_cout = alu_opA[0]; end
      OP_XOR:    alu_result = alu_opA ^ alu_opB;
      OP_CMP:    alu_result = (alu_opA == alu_opB) ? 8'h01 :
                              (alu_opA >  alu_opB) ? 8'h02 : 8'h03;
      OP_AND:    alu_result = alu_opA & alu_opB;
      OP_NAND:   alu_result = ~(alu_opA & alu_opB);
      OP_OR:     alu_result = alu_opA | alu_opB;
      OP_NOR:    alu_result = ~(alu_opA | alu_opB);
      default:   alu_result = '0;
    endcase
  end

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  exp_res;
    logic        exp_c;
    logic        exp_z;
    logic        chk_alu;
    logic        exp_cin;
    logic [1:0]  reg_a;
    logic [7:0]  exp_reg;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  logic [3:0] exec_opc;
  logic       exec_cin;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] d,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic uc);
    return {op, d, sa, sb, uc, 5'b00000};
  endfunction

  function automatic logic [15:0] li(input logic [1:0] d, input logic [7:0] imm);
    return {OP_LOADI, d, 2'b00, imm};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one instruction; returns at the negedge inside the res_valid cycle
  task automatic issue(input logic [15:0] ins);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
    exec_opc = alu_opcode;
    exec_cin = alu_cin;
    n = 0;
    while (!res_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) chk("res_valid_timeout", 16'(res_valid), 16'h1);
  endtask

  task automatic chk_reg(input string nm, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk(nm, 16'(rd_data), 16'(exp));
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    rd_addr  = '0;

    //              ins                        res    c     z     alu   cin   reg    val
    vecs[0]  = '{li(2'd0, 8'hFF),              8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'hFF};
    vecs[1]  = '{li(2'd1, 8'h01),              8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h01};
    vecs[2]  = '{mk(OP_ADD, 2, 0, 1, 0),       8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 8'h00};
    vecs[3]  = '{mk(OP_ADD, 3, 1, 1, 1),       8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 8'h03};
    vecs[4]  = '{li(2'd0, 8'h80),              8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h80};
    vecs[5]  = '{mk(OP_ADD, 2, 0, 0, 0),       8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 8'h00};
    vecs[6]  = '{mk(OP_LSHIFT, 1, 0, 0, 1),    8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h01};
    vecs[7]  = '{li(2'd0, 8'h05),              8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h05};
    vecs[8]  = '{li(2'd1, 8'h09),              8'h09, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'h09};
    vecs[9]  = '{mk(OP_CMP, 2, 0, 1, 0),       8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'h03};
    vecs[10] = '{mk(OP_CMP, 3, 1, 1, 0),       8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 8'h01};
    vecs[11] = '{mk(OP_CMP, 3, 1, 0, 0),       8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 8'h02};
    vecs[12] = '{mk(OP_SUB, 2, 1, 0, 0),       8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'h04};
    vecs[13] = '{mk(OP_SUB, 0, 0, 0, 0),       8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
    vecs[14] = '{mk(4'hB, 1, 0, 0, 0),         8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h09};
    vecs[15] = '{mk(OP_XOR, 3, 1, 2, 0),       8'h0D, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 8'h0D};
    vecs[16] = '{mk(OP_AND, 3, 1, 2, 0),       8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 8'h00};
    vecs[17] = '{mk(OP_NAND, 3, 1, 2, 0),      8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 8'hFF};
    vecs[18] = '{mk(OP_OR, 3, 1, 2, 0),        8'h0D, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 8'h0D};
    vecs[19] = '{mk(OP_NOR, 3, 1, 2, 0),       8'hF2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 8'hF2};
    vecs[20] = '{mk(OP_RSHIFT, 3, 1, 0, 1),    8'h84, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 8'h84};
    vecs[21] = '{mk(OP_ADD, 0, 1, 2, 1),       8'h0E, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 8'h0E};
    vecs[22] = '{li(2'd3, 8'h00),              8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready",  16'(in_ready),   16'h1);
    chk("rst_res_valid", 16'(res_valid),  16'h0);
    chk("rst_res_data",  16'(res_data),   16'h0);
    chk("rst_flag_c",    16'(flag_c),     16'h0);
    chk("rst_flag_z",    16'(flag_z),     16'h0);
    chk("rst_alu_opc",   16'(alu_opcode), 16'h0);
    chk("rst_alu_opa",   16'(alu_opA),    16'h0);
    chk("rst_alu_opb",   16'(alu_opB),    16'h0);
    chk("rst_alu_cin",   16'(alu_cin),    16'h0);
    for (int r = 0; r < 4; r++) chk_reg($sformatf("rst_reg%0d", r), 2'(r), 8'h00);

    // Directed instruction table
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].ins);
      if (vecs[i].chk_alu) begin
        chk($sformatf("v%0d alu_opcode", i), 16'(exec_opc), 16'(vecs[i].ins[15:12]));
        chk($sformatf("v%0d alu_cin", i),    16'(exec_cin), 16'(vecs[i].exp_cin));
      end
      chk($sformatf("v%0d res_data", i), 16'(res_data), 16'(vecs[i].exp_res));
      chk($sformatf("v%0d in_ready", i), 16'(in_ready), 16'h0);
      chk($sformatf("v%0d flag_c", i),   16'(flag_c),   16'(vecs[i].exp_c));
      chk($sformatf("v%0d flag_z", i),   16'(flag_z),   16'(vecs[i].exp_z));
      chk_reg($sformatf("v%0d reg", i), vecs[i].reg_a, vecs[i].exp_reg);
    end

    // in_valid held high with NOPs: ready 1,0,0 and one res_valid per 3 cycles
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = mk(4'hA, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b2b%0d in_ready", i),  16'(in_ready),  16'((i % 3) == 0));
      chk($sformatf("b2b%0d res_valid", i), 16'(res_valid), 16'((i % 3) == 2));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b res_data", 16'(res_data), 16'h0);
    chk("b2b flag_c", 16'(flag_c), 16'h0);
    chk_reg("b2b reg0", 2'd0, 8'h0E);
    chk_reg("b2b reg1", 2'd1, 8'h09);
    chk_reg("b2b reg2", 2'd2, 8'h04);

    // Reset asserted during EXEC aborts the instruction
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = mk(OP_ADD, 1, 1, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort in_exec_ready", 16'(in_ready), 16'h0);
    rst = 1'b1;
    #1;
    chk("abort in_ready", 16'(in_ready), 16'h1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort%0d res_valid", i), 16'(res_valid), 16'h0);
      @(negedge clk);
    end
    chk("abort res_data", 16'(res_data), 16'h0);
    chk("abort flag_c",   16'(flag_c),   16'h0);
    chk("abort flag_z",   16'(flag_z),   16'h0);
    chk("abort alu_opa",  16'(alu_opA),  16'h0);
    chk("abort in_ready2", 16'(in_ready), 16'h1);
    for (int r = 0; r < 4; r++) chk_reg($sformatf("abort_reg%0d", r), 2'(r), 8'h00);

    // Sequencer still works after the abort
    issue(li(2'd2, 8'h5A));
    chk("post_abort res_data", 16'(res_data), 16'h5A);
    chk_reg("post_abort reg2", 2'd2, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
